seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the 4-bit combinational adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, through a single CHUNK-bit adder slice with a registered carry.
- Valid/ready handshake on both input and output.
- Used where wide arithmetic must trade latency for area, and as the reusable arithmetic core for later datapath blocks.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be ≥ 1.
- CHUNK, 4: bits processed per cycle. Must divide WIDTH exactly. CHUNK == WIDTH gives single-pass operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set is presented.
- in_ready  output  1  block can accept an operand set.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (subtract).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out. In subtract mode, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset:
  - Asynchronous; takes effect immediately regardless of clk.
  - state = IDLE; out_valid = 0; sum = 0; cout = 0; ovf = 0; internal carry and chunk counter = 0.
  - in_ready = 1 while in IDLE.
- Arithmetic:
  - sub = 0: {cout, sum} = a + b + cin.
  - sub = 1: {cout, sum} = a + ~b + !cin, i.e. sum = a - b - cin modulo 2^WIDTH.
  - ovf = carry into the MSB XOR carry out of the MSB.
  - Results must be bit-exact against these formulas for every WIDTH/CHUNK combination.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
    - On the edge where in_valid && in_ready, latch a, the effective b (b or ~b), the initial carry (cin or !cin) and sub.
    - Clear the chunk counter and go to RUN.
    - While in_valid is low, stay in IDLE.
  - RUN: in_ready = 0, out_valid = 0.
    - Each cycle, add chunk index k (bits k*CHUNK .. k*CHUNK+CHUNK-1) with the registered carry.
    - Write the chunk result into sum[chunk k], update the carry register and increment k.
    - On the edge that processes the last chunk (k = WIDTH/CHUNK - 1):
      - register cout and ovf (ovf uses the carries around bit WIDTH-1);
      - go to DONE.
  - DONE: out_valid = 1, in_ready = 0.
    - sum, cout and ovf stay stable until the handshake completes.
    - On the edge where out_valid && out_ready, go to IDLE; sum, cout and ovf keep their values.
    - While out_ready is low, remain in DONE indefinitely.
- Latency: if the operand set is accepted on edge t, out_valid is high after edge t + WIDTH/CHUNK.
- Throughput: at most one operation in flight. No overlap of accept and deliver: in_ready stays low in DONE even if out_ready is high.
- Intermediate values: sum is visible but undefined to the consumer while out_valid = 0. Its partial contents during RUN are not part of the contract.
- Input timing: in_valid, a, b, cin and sub are ignored outside IDLE. Changes to inputs after acceptance have no effect on the result.
- Reset mid-operation: the operation is aborted with no output produced, and all outputs take their reset values.

Test Plan:
- Unsigned wrap-around: WIDTH = 16, CHUNK = 4; add 0xFFFF + 0x0001, cin = 0 → sum = 0x0000, cout = 1, ovf = 0. out_valid rises exactly 4 cycles after acceptance.
- Signed overflow: add 0x7FFF + 0x0001, cin = 0 → sum = 0x8000, cout = 0, ovf = 1. Add 0x8000 + 0x8000 → sum = 0x0000, cout = 1, ovf = 1.
- Subtract with borrow: 0x0005 - 0x0007, cin = 0 → sum = 0xFFFE, cout = 0, ovf = 0. 0x0007 - 0x0005, cin = 1 → sum = 0x0001, cout = 1.
- Backpressure: hold out_ready = 0 for 3 cycles after out_valid rises → sum, cout and ovf unchanged and in_ready = 0. A new in_valid pulse during this time is not accepted. Raise out_ready → in_ready = 1 on the next cycle.
- Reset mid-RUN: assert rst 2 cycles after acceptance → out_valid = 0 and sum = 0 immediately. After release, a fresh 0x1234 + 0x1111 gives 0x2345.
- Exhaustive degenerate case: WIDTH = 4, CHUNK = 4, all a, b, cin, sub combinations (1024) → {cout, sum} matches the formulas and latency is 1 cycle. Repeat with CHUNK = 1, expecting latency 4.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: walks a WIDTH-bit operand pair through one
// CHUNK-bit adder slice, LSB chunk first, with valid/ready on both sides.
module seq_chunk_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : gBadParams
      $error("seq_chunk_adder: CHUNK must divide WIDTH exactly");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} stateType;

   stateType         state;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic             carry;
   logic [CW-1:0]    chunkIdx;
   logic [CHUNK-1:0] sliceA;
   logic [CHUNK-1:0] sliceB;
   logic [CHUNK:0]   sliceSum;
   logic             msbCarryIn;
   logic             lastChunk;

   // Operands shift right each cycle, so the active chunk always sits in the low bits.
   assign sliceA     = opA[CHUNK-1:0];
   assign sliceB     = opB[CHUNK-1:0];
   assign sliceSum   = {1'b0, sliceA} + {1'b0, sliceB} + {{CHUNK{1'b0}}, carry};
   assign msbCarryIn = sliceA[CHUNK-1] ^ sliceB[CHUNK-1] ^ sliceSum[CHUNK-1];
   assign lastChunk  = (chunkIdx == CW'(NCHUNK - 1));

   // Handshake FSM; subtraction is folded into the latched operand as a + ~b + !cin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         opA       <= '0;
         opB       <= '0;
         carry     <= 1'b0;
         chunkIdx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opA      <= a;
                  opB      <= sub ? ~b : b;
                  carry    <= sub ? ~cin : cin;
                  chunkIdx <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               opA      <= opA >> CHUNK;
               opB      <= opB >> CHUNK;
               sum      <= (sum >> CHUNK) | (WIDTH'(sliceSum[CHUNK-1:0]) << (WIDTH - CHUNK));
               carry    <= sliceSum[CHUNK];
               chunkIdx <= chunkIdx + CW'(1);
               if (lastChunk) begin
                  cout      <= sliceSum[CHUNK];
                  ovf       <= msbCarryIn ^ sliceSum[CHUNK];
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three instances (16/4, 4/1, 4/4) checked every
// cycle against a transaction-level model, plus directed literal cases.
module tb_seq_chunk_adder;

   localparam int NDUT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inValid[NDUT];
   logic        outReady[NDUT];
   logic        cinIn[NDUT];
   logic        subIn[NDUT];
   logic [15:0] aIn[NDUT];
   logic [15:0] bIn[NDUT];
   logic        inReady[NDUT];
   logic        outValid[NDUT];
   logic        coutOut[NDUT];
   logic        ovfOut[NDUT];
   logic [15:0] sumOut[NDUT];
   logic [15:0] sum0;
   logic [3:0]  sum1;
   logic [3:0]  sum2;

   int checks = 0;
   int passes = 0;

   bit          mBusy[NDUT];
   bit          mValid[NDUT];
   int          mCount[NDUT];
   logic [15:0] mSum[NDUT];
   logic        mCout[NDUT];
   logic        mOvf[NDUT];
   logic [17:0] pending[NDUT];

   always #5 clk = ~clk;

   function automatic int widthOf(int d);
      return (d == 0) ? 16 : 4;
   endfunction

   function automatic int latencyOf(int d);
      return (d == 0) ? 4 : (d == 1) ? 4 : 1;
   endfunction

   seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
      .a(aIn[0]), .b(bIn[0]), .cin(cinIn[0]), .sub(subIn[0]),
      .out_valid(outValid[0]), .out_ready(outReady[0]),
      .sum(sum0), .cout(coutOut[0]), .ovf(ovfOut[0]));

   seq_chunk_adder #(.WIDTH(4), .CHUNK(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
      .a(aIn[1][3:0]), .b(bIn[1][3:0]), .cin(cinIn[1]), .sub(subIn[1]),
      .out_valid(outValid[1]), .out_ready(outReady[1]),
      .sum(sum1), .cout(coutOut[1]), .ovf(ovfOut[1]));

   seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut2 (
      .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
      .a(aIn[2][3:0]), .b(bIn[2][3:0]), .cin(cinIn[2]), .sub(subIn[2]),
      .out_valid(outValid[2]), .out_ready(outReady[2]),
      .sum(sum2), .cout(coutOut[2]), .ovf(ovfOut[2]));

   always_comb begin
      sumOut[0] = sum0;
      sumOut[1] = {12'h000, sum1};
      sumOut[2] = {12'h000, sum2};
   end

   // Reference arithmetic straight from the formulas: returns {ovf, cout, sum}.
   function automatic logic [17:0] refResult(int w, logic [15:0] av, logic [15:0] bv,
                                             logic c, logic s);
      logic [31:0] mask;
      logic [31:0] beff;
      logic [31:0] tot;
      logic        sa;
      logic        sb;
      logic        ss;
      mask = (32'd1 << w) - 32'd1;
      beff = s ? (~{16'h0000, bv} & mask) : ({16'h0000, bv} & mask);
      tot  = ({16'h0000, av} & mask) + beff + {31'd0, (s ? ~c : c)};
      sa   = av[w-1];
      sb   = beff[w-1];
      ss   = tot[w-1];
      return {(sa == sb) && (ss != sa), tot[w], tot[15:0] & mask[15:0]};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Transaction model: one operation in flight, result appears after a fixed latency.
   always @(posedge clk or posedge rst) begin
      for (int d = 0; d < NDUT; d++) begin
         if (rst) begin
            mBusy[d]  = 1'b0;
            mValid[d] = 1'b0;
            mCount[d] = 0;
            mSum[d]   = '0;
            mCout[d]  = 1'b0;
            mOvf[d]   = 1'b0;
         end else if (mBusy[d]) begin
            mCount[d] = mCount[d] - 1;
            if (mCount[d] == 0) begin
               mBusy[d]  = 1'b0;
               mValid[d] = 1'b1;
               {mOvf[d], mCout[d], mSum[d]} = pending[d];
            end
         end else if (mValid[d]) begin
            if (outReady[d]) mValid[d] = 1'b0;
         end else if (inValid[d]) begin
            pending[d] = refResult(widthOf(d), aIn[d], bIn[d], cinIn[d], subIn[d]);
            mCount[d]  = latencyOf(d);
            mBusy[d]   = 1'b1;
         end
      end
   end

   // Per-cycle comparison; the result fields are only meaningful outside RUN.
   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("dut%0d in_ready", d), inReady[d], !mBusy[d] && !mValid[d]);
         check($sformatf("dut%0d out_valid", d), outValid[d], mValid[d]);
         if (!mBusy[d]) begin
            check($sformatf("dut%0d sum", d), sumOut[d], mSum[d]);
            check($sformatf("dut%0d cout", d), coutOut[d], mCout[d]);
            check($sformatf("dut%0d ovf", d), ovfOut[d], mOvf[d]);
         end
      end
   end

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic applyStimulus(int d, logic [15:0] av, logic [15:0] bv, logic c, logic s);
      int waited = 0;
      inValid[d] = 1'b1;
      aIn[d]     = av;
      bIn[d]     = bv;
      cinIn[d]   = c;
      subIn[d]   = s;
      while (!inReady[d] && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check($sformatf("dut%0d accept timeout", d), inReady[d], 1'b1);
      @(negedge clk);
      inValid[d] = 1'b0;
      aIn[d]     = 16'($urandom);
      bIn[d]     = 16'($urandom);
      cinIn[d]   = 1'($urandom);
      subIn[d]   = 1'($urandom);
   endtask

   task automatic checkOutput(int d, int expLat, bit literal, logic [15:0] eSum,
                              logic eCout, logic eOvf, int hold, bit consume);
      int lat = 0;
      while (!outValid[d] && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("dut%0d latency", d), lat, expLat);
      if (literal) begin
         check($sformatf("dut%0d literal sum", d), sumOut[d], eSum);
         check($sformatf("dut%0d literal cout", d), coutOut[d], eCout);
         check($sformatf("dut%0d literal ovf", d), ovfOut[d], eOvf);
      end
      if (consume) begin
         repeat (hold) @(negedge clk);
         outReady[d] = 1'b1;
         @(negedge clk);
         outReady[d] = 1'b0;
      end
   endtask

   initial begin
      for (int d = 0; d < NDUT; d++) begin
         inValid[d]  = 1'b0;
         outReady[d] = 1'b0;
         aIn[d]      = '0;
         bIn[d]      = '0;
         cinIn[d]    = 1'b0;
         subIn[d]    = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("reset out_valid", outValid[0], 1'b0);
      check("reset in_ready", inReady[0], 1'b1);
      check("reset sum", sumOut[0], 16'h0000);
      check("reset cout", coutOut[0], 1'b0);
      check("reset ovf", ovfOut[0], 1'b0);
      #2 rst = 1'b0;
      @(negedge clk);

      applyStimulus(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      checkOutput(0, 4, 1'b1, 16'h0000, 1'b1, 1'b0, 0, 1'b1);
      applyStimulus(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      checkOutput(0, 4, 1'b1, 16'h8000, 1'b0, 1'b1, 0, 1'b1);
      applyStimulus(0, 16'h0005, 16'h0007, 1'b0, 1'b1);
      checkOutput(0, 4, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1, 1'b1);
      applyStimulus(0, 16'h0007, 16'h0005, 1'b1, 1'b1);
      checkOutput(0, 4, 1'b1, 16'h0001, 1'b1, 1'b0, 0, 1'b1);

      // Backpressure: result must hold and a stray in_valid must be ignored.
      applyStimulus(0, 16'h8000, 16'h8000, 1'b0, 1'b0);
      checkOutput(0, 4, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
      inValid[0] = 1'b1;
      aIn[0]     = 16'h0101;
      bIn[0]     = 16'h0202;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         inValid[0] = 1'b0;
         check("hold sum", sumOut[0], 16'h0000);
         check("hold cout", coutOut[0], 1'b1);
         check("hold ovf", ovfOut[0], 1'b1);
         check("hold in_ready", inReady[0], 1'b0);
      end
      outReady[0] = 1'b1;
      @(negedge clk);
      outReady[0] = 1'b0;
      check("release in_ready", inReady[0], 1'b1);
      check("release out_valid", outValid[0], 1'b0);

      // Abort mid-RUN with reset; then a fresh operation must complete normally.
      applyStimulus(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrun out_valid", outValid[0], 1'b0);
      check("midrun sum", sumOut[0], 16'h0000);
      check("midrun in_ready", inReady[0], 1'b1);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      applyStimulus(0, 16'h1234, 16'h1111, 1'b0, 1'b0);
      checkOutput(0, 4, 1'b1, 16'h2345, 1'b0, 1'b0, 0, 1'b1);

      for (int i = 0; i < 150; i++) begin
         applyStimulus(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         checkOutput(0, 4, 1'b0, 16'h0000, 1'b0, 1'b0, $urandom_range(0, 3), 1'b1);
      end

      for (int d = 1; d < NDUT; d++) begin
         outReady[d] = 1'b0;
         for (int v = 0; v < 1024; v++) begin
            applyStimulus(d, 16'(v & 15), 16'((v >> 4) & 15), v[8], v[9]);
            checkOutput(d, latencyOf(d), 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1);
         end
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
